// File: rtl/user_sobel_core.sv
// Streaming 3x3 Sobel edge detector for the VIP greyscale path.
// Two line buffers feed a sliding window; gradients and magnitude take two more stages.
module user_sobel_core #(
   parameter int BITS_PER_SYMBOL  = 8,
   parameter int SYMBOLS_PER_BEAT = 3,
   parameter int MAX_WIDTH        = 1024,
   parameter int BINARY           = 0,
   parameter int THRESHOLD        = 128
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         stall_in,
   output logic                                         read,
   input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0]  data_in,
   input  logic                                         end_of_video,
   input  logic [15:0]                                  width_in,
   input  logic [15:0]                                  height_in,
   input  logic [3:0]                                   interlaced_in,
   input  logic                                         vip_ctrl_valid,
   input  logic                                         stall_out,
   output logic                                         write,
   output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0]  data_out,
   output logic                                         end_of_video_out,
   output logic [15:0]                                  width_out,
   output logic [15:0]                                  height_out,
   output logic [3:0]                                   interlaced_out,
   input  logic                                         vip_ctrl_busy,
   output logic                                         vip_ctrl_send
);
   localparam int BW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
   localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam logic [10:0] THR = 11'(THRESHOLD);

   logic [7:0] lb0_q [MAX_WIDTH];
   logic [7:0] lb1_q [MAX_WIDTH];

   logic [15:0] col_q, col_d, row_q, row_d;
   logic [2:0][2:0][7:0] win_q, win_d;
   logic [2:0] vld_pipe_q, vld_pipe_d, eov_pipe_q, eov_pipe_d;
   logic [1:0] bdr_pipe_q, bdr_pipe_d;
   logic [9:0] absx_q, absx_d, absy_q, absy_d;
   logic [7:0] res_q, res_d;
   logic [15:0] width_q, width_d, height_q, height_d;
   logic [3:0] il_q, il_d;
   logic send_q, send_d;

   logic acc, adv, in_rng;
   logic [AW-1:0] addr;
   logic [7:0] top, mid, bot;
   logic [9:0] sum_l, sum_r, sum_t, sum_b;
   logic [10:0] gx, gy, gx_abs, gy_abs, mag;
   logic unused_hi;

   assign acc     = ~stall_out & ~stall_in;
   assign adv     = ~stall_out;
   assign in_rng  = {16'd0, col_q} < 32'(MAX_WIDTH);
   assign addr    = in_rng ? col_q[AW-1:0] : '0;
   assign top     = lb1_q[addr];
   assign mid     = lb0_q[addr];
   assign bot     = data_in[7:0];
   assign unused_hi = ^data_in[BW-1:BITS_PER_SYMBOL];

   // Window is indexed [row][col]; row 0 is two lines back, col 2 is the newest column.
   assign sum_l = {2'b0, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b0, win_q[2][0]};
   assign sum_r = {2'b0, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0} + {2'b0, win_q[2][2]};
   assign sum_t = {2'b0, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b0, win_q[0][2]};
   assign sum_b = {2'b0, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b0, win_q[2][2]};
   assign gx     = {1'b0, sum_r} - {1'b0, sum_l};
   assign gy     = {1'b0, sum_b} - {1'b0, sum_t};
   assign gx_abs = gx[10] ? (~gx + 11'd1) : gx;
   assign gy_abs = gy[10] ? (~gy + 11'd1) : gy;
   assign mag    = {1'b0, absx_q} + {1'b0, absy_q};

   always_comb begin
      col_d      = col_q;
      row_d      = row_q;
      win_d      = win_q;
      vld_pipe_d = vld_pipe_q;
      eov_pipe_d = eov_pipe_q;
      bdr_pipe_d = bdr_pipe_q;
      absx_d     = absx_q;
      absy_d     = absy_q;
      res_d      = res_q;
      if (vip_ctrl_valid || (acc && end_of_video)) begin
         col_d = '0;
         row_d = '0;
      end else if (acc) begin
         if (col_q == width_q - 16'd1) begin
            col_d = '0;
            row_d = row_q + 16'd1;
         end else begin
            col_d = col_q + 16'd1;
         end
      end
      if (acc) begin
         win_d[0][0] = win_q[0][1];
         win_d[1][0] = win_q[1][1];
         win_d[2][0] = win_q[2][1];
         win_d[0][1] = win_q[0][2];
         win_d[1][1] = win_q[1][2];
         win_d[2][1] = win_q[2][2];
         win_d[0][2] = top;
         win_d[1][2] = mid;
         win_d[2][2] = bot;
      end
      if (adv) begin
         vld_pipe_d = {vld_pipe_q[1:0], acc};
         eov_pipe_d = {eov_pipe_q[1:0], acc & end_of_video};
         // Zero border: window not yet full of this frame's pixels, or past the buffers.
         bdr_pipe_d = {bdr_pipe_q[0], (row_q < 16'd2) || (col_q < 16'd2) || !in_rng};
         absx_d     = gx_abs[9:0];
         absy_d     = gy_abs[9:0];
         if (bdr_pipe_q[1])
            res_d = '0;
         else if (BINARY != 0)
            res_d = (mag >= THR) ? 8'hFF : 8'h00;
         else
            res_d = (mag > 11'd255) ? 8'hFF : mag[7:0];
      end
   end

   always_comb begin
      width_d  = vip_ctrl_valid ? width_in      : width_q;
      height_d = vip_ctrl_valid ? height_in     : height_q;
      il_d     = vip_ctrl_valid ? interlaced_in : il_q;
      send_d   = vip_ctrl_valid & ~vip_ctrl_busy;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q      <= '0;
         row_q      <= '0;
         win_q      <= '0;
         vld_pipe_q <= '0;
         eov_pipe_q <= '0;
         bdr_pipe_q <= '0;
         absx_q     <= '0;
         absy_q     <= '0;
         res_q      <= '0;
         width_q    <= 16'd640;
         height_q   <= 16'd480;
         il_q       <= '0;
         send_q     <= 1'b0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         win_q      <= win_d;
         vld_pipe_q <= vld_pipe_d;
         eov_pipe_q <= eov_pipe_d;
         bdr_pipe_q <= bdr_pipe_d;
         absx_q     <= absx_d;
         absy_q     <= absy_d;
         res_q      <= res_d;
         width_q    <= width_d;
         height_q   <= height_d;
         il_q       <= il_d;
         send_q     <= send_d;
      end
   end

   // Line buffers are plain RAM; stale contents are hidden by the border mask.
   always_ff @(posedge clk) begin
      if (acc && in_rng) begin
         lb1_q[addr] <= mid;
         lb0_q[addr] <= bot;
      end
   end

   assign read             = ~stall_out;
   assign write            = vld_pipe_q[2];
   assign data_out         = {SYMBOLS_PER_BEAT{res_q}};
   assign end_of_video_out = eov_pipe_q[2];
   assign width_out        = width_q;
   assign height_out       = height_q;
   assign interlaced_out   = il_q;
   assign vip_ctrl_send    = send_q;
endmodule

// File: doc/user_sobel_core.md
Name: user_sobel_core

Overview:
- Streaming 3x3 Sobel edge detector that sits directly downstream of the RGB-to-greyscale core, inside the VIP flow-control wrapper.
- Consumes greyscale beats (symbol 0 of each 24-bit beat) and buffers two lines in on-chip RAM.
- Emits one edge-magnitude beat per accepted input beat, replicated on all 3 symbols.
- Passes the VIP control packet (width/height/interlaced) through to the encoder.

Parameters:
- BITS_PER_SYMBOL, 8, bits per colour symbol; the block supports 8 only.
- SYMBOLS_PER_BEAT, 3, symbols per beat; output replicates the result on every symbol.
- MAX_WIDTH, 1024, depth of each line buffer in pixels.
- BINARY, 0, 1 selects thresholded output; 0 selects clamped magnitude.
- THRESHOLD, 128, magnitude compare value used when BINARY=1 (11-bit).

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-low reset; asserted at 0.
- stall_in  in  1  upstream has no beat this cycle.
- read  out  1  block requests a beat.
- data_in  in  24  input beat; [7:0] = grey value, [23:8] ignored.
- end_of_video  in  1  marks the last beat of the frame.
- width_in  in  16  control-packet width.
- height_in  in  16  control-packet height.
- interlaced_in  in  4  control-packet interlace field.
- vip_ctrl_valid  in  1  control fields are valid this cycle.
- stall_out  in  1  downstream cannot accept a beat.
- write  out  1  output beat is valid.
- data_out  out  24  {mag,mag,mag}.
- end_of_video_out  out  1  end-of-video flag aligned with data_out.
- width_out  out  16  registered width to the encoder.
- height_out  out  16  registered height to the encoder.
- interlaced_out  out  4  registered interlace field to the encoder.
- vip_ctrl_busy  in  1  encoder is busy.
- vip_ctrl_send  out  1  request to send the control packet.

Behaviour:
- Reset (rst=0, asynchronous), all outputs and state clear to:
  - write=0, data_out=0, end_of_video_out=0, vip_ctrl_send=0.
  - width_out=640, height_out=480, interlaced_out=0.
  - col=row=0, all pipeline valid bits 0.
- Line-buffer RAM contents are not reset; the border mask makes them irrelevant.
- Flow control:
  - read = ~stall_out; a beat is accepted when read & ~stall_in.
  - Pipeline stages P0 (window), P1 (gradients), P2 (output) advance only when stall_out=0.
  - When stall_out=1 every register holds, including the window, line buffers and counters.
  - Bubbles propagate as valid=0.
  - write = P2.valid; a beat is consumed when write & ~stall_out.
- Latency: 3 clk edges from acceptance to write=1 when unstalled; each stall cycle adds exactly one.
- Counters:
  - col increments on each accepted beat; at col = width_out-1 it wraps to 0 and row increments.
  - An accepted beat with end_of_video=1 forces col=row=0 on the next edge.
  - vip_ctrl_valid=1 also forces col=row=0.
  - If acceptance and vip_ctrl_valid coincide, the reset to 0 wins.
- Line buffers lb0 (previous row) and lb1 (two rows back) are addressed by col. On acceptance at column c:
  - column in: top=lb1[c], mid=lb0[c], bot=new.
  - lb1[c] <= lb0[c]; lb0[c] <= new.
  - The 3x3 window shifts left by one column.
- Columns c >= MAX_WIDTH are not written, and their output is 0.
- Gradients (P1):
  - Gx = (p02+2p12+p22) - (p00+2p10+p20).
  - Gy = (p20+2p21+p22) - (p00+2p01+p02).
  - Each is 11-bit signed, range ±1020; P1 registers |Gx| and |Gy| (10-bit).
- Output (P2):
  - mag = |Gx|+|Gy|, 11-bit.
  - BINARY=0: result = min(mag,255).
  - BINARY=1: result = (mag >= THRESHOLD) ? 255 : 0.
- Alignment:
  - The output for the beat accepted at (row,col) is the window centred at (row-1,col-1).
  - Output is forced to 0 when row<2 or col<2.
  - The image is therefore shifted one pixel down-right with a zero border; no flush beats are generated.
- end_of_video travels with its pixel through P0..P2 onto end_of_video_out.
- Control path, registered each edge:
  - width/height/interlaced_out load the input fields when vip_ctrl_valid=1, otherwise hold.
  - vip_ctrl_send <= vip_ctrl_valid & ~vip_ctrl_busy.
- Reset mid-frame: the pipeline empties immediately and the next accepted beat is treated as (0,0).

Test Plan:
- Reset: hold rst=0 for 3 cycles then release -> write=0, width_out=640, height_out=480, vip_ctrl_send=0.
- Constant frame: vip_ctrl width=8 height=4, 32 beats of grey 0x50 -> 32 writes, all data_out=0x000000; end_of_video_out=1 only on the 32nd.
- Vertical step, BINARY=0: width=8 height=4, cols 0-3=0 and cols 4-7=100 ->
  - rows 2-3, cols 4 and 5 = 0xFFFFFF (mag 400 clamped);
  - every other beat = 0;
  - first write occurs 3 edges after the first accepted beat.
- Threshold: BINARY=1, THRESHOLD=500, same step frame -> all zeros; with THRESHOLD=400 -> 0xFFFFFF at the same positions.
- Backpressure: vertical-step frame with stall_out toggled 1/0 every 2 cycles and random stall_in -> output sequence identical to the unstalled run; read=0 whenever stall_out=1; no beat is lost or duplicated.
- Mid-row end_of_video: assert end_of_video on beat 5 of a width-8 row, then start a new frame -> the new frame's first two rows and columns output 0, and the Sobel result matches the reference model from (0,0).
